// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencer sharing one ALU and one memory port.
// Memory is a req/ack handshake held until ack; illegal opcodes and (optionally) misaligned addresses halt the core.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter bit          HALT_ON_MISALIGN = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic [31:0] PCOut,
  output logic        InstrRetired,
  output logic        Halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] F_JR  = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24, F_OR  = 6'h25, F_SLT = 6'h2A;

  state_t      state, state_nx;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] regs [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wb_addr;
  logic [31:0] imm_sext, r_result, mem_addr_raw, wb_data;
  logic        is_ralu, is_jr, is_mem, is_sw, is_lw, legal, exec_halt;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};

  assign is_ralu = (opcode == OP_RTYPE) &&
                   (funct == F_ADD || funct == F_SUB || funct == F_AND ||
                    funct == F_OR  || funct == F_SLT);
  assign is_jr   = (opcode == OP_RTYPE) && (funct == F_JR);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_mem  = is_lw || is_sw;
  assign legal   = is_ralu || is_jr || is_mem || opcode == OP_J || opcode == OP_JAL ||
                   opcode == OP_BEQ || opcode == OP_ADDI;

  assign mem_addr_raw = a + imm_sext;
  assign exec_halt    = HALT_ON_MISALIGN &&
                        ((is_mem && mem_addr_raw[1:0] != 2'b00) || (is_jr && a[1:0] != 2'b00));

  always_comb begin
    r_result = 32'h0;
    case (funct)
      F_ADD:   r_result = a + b;
      F_SUB:   r_result = a - b;
      F_AND:   r_result = a & b;
      F_OR:    r_result = a | b;
      F_SLT:   r_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r_result = 32'h0;
    endcase
  end

  assign wb_addr = is_ralu ? rd : rt;
  assign wb_data = is_lw ? mdr : alu_out;

  always_comb begin
    state_nx     = state;
    MemReq       = 1'b0;
    MemWe        = 1'b0;
    MemAddr      = 32'h0;
    InstrRetired = 1'b0;
    case (state)
      S_IDLE:   state_nx = S_FETCH;
      S_FETCH: begin
        MemReq  = 1'b1;
        MemAddr = pc;
        if (MemAck) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (exec_halt)                       state_nx = S_HALT;
        else if (is_ralu || opcode == OP_ADDI) state_nx = S_WB;
        else if (is_mem)                     state_nx = S_MEM;
        else begin
          InstrRetired = 1'b1;
          state_nx     = S_FETCH;
        end
      end
      S_MEM: begin
        MemReq  = 1'b1;
        MemWe   = is_sw;
        MemAddr = alu_out;
        if (MemAck) begin
          InstrRetired = is_sw;
          state_nx     = is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        InstrRetired = 1'b1;
        state_nx     = S_FETCH;
      end
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign MemWData = b;
  assign PCOut    = pc;
  assign Halted   = (state == S_HALT);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= 32'h0;
      a       <= 32'h0;
      b       <= 32'h0;
      alu_out <= 32'h0;
      mdr     <= 32'h0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else begin
      state <= state_nx;
      case (state)
        S_FETCH: if (MemAck) begin
          ir <= MemRData;
          pc <= pc + 32'd4;
        end
        S_DECODE: begin
          a       <= regs[rs];
          b       <= regs[rt];
          alu_out <= pc + (imm_sext << 2);
        end
        S_EXEC: if (!exec_halt) begin
          // Misaligned addresses only get here when they are to be truncated.
          if (is_ralu)                 alu_out <= r_result;
          else if (opcode == OP_ADDI)  alu_out <= mem_addr_raw;
          else if (is_mem)             alu_out <= {mem_addr_raw[31:2], 2'b00};
          else if (opcode == OP_BEQ)   begin if (a == b) pc <= alu_out; end
          else if (opcode == OP_J)     pc <= {pc[31:28], ir[25:0], 2'b00};
          else if (opcode == OP_JAL) begin
            pc       <= {pc[31:28], ir[25:0], 2'b00};
            regs[31] <= pc;
          end
          else if (is_jr)              pc <= {a[31:2], 2'b00};
        end
        S_MEM: if (MemAck && is_lw) mdr <= MemRData;
        S_WB: if (wb_addr != 5'd0) regs[wb_addr] <= wb_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: directed programs plus randomized ALU programs checked against an ISA-level model.
module tb_multicycle_datapath;
  localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
  localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;
  localparam logic [31:0] NOREQ = 32'hDEAD_BEEF;

  logic        Clk, Rst, Rst0;
  logic        MemReq, MemWe, MemAck, InstrRetired, Halted;
  logic [31:0] MemAddr, MemWData, MemRData, PCOut;
  logic        MemReq0, MemWe0, InstrRetired0, Halted0;
  logic [31:0] MemAddr0, MemWData0, PCOut0, MemRData0;
  logic        MemAck0;

  logic [31:0] mem [0:1023];
  int checks = 0, failures = 0;
  int fetch_delay = 0, data_delay = 0, wait_cnt = 0;

  multicycle_datapath dut (
    .Clk(Clk), .Rst(Rst), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck), .PCOut(PCOut),
    .InstrRetired(InstrRetired), .Halted(Halted));

  multicycle_datapath #(.HALT_ON_MISALIGN(1'b0)) dut0 (
    .Clk(Clk), .Rst(Rst0), .MemReq(MemReq0), .MemWe(MemWe0), .MemAddr(MemAddr0),
    .MemWData(MemWData0), .MemRData(MemRData0), .MemAck(MemAck0), .PCOut(PCOut0),
    .InstrRetired(InstrRetired0), .Halted(Halted0));

  // The second core only ever reads, with zero wait states.
  assign MemAck0   = 1'b1;
  assign MemRData0 = mem[MemAddr0[11:2]];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Memory responder: ack after a programmable number of wait cycles.
  initial begin
    MemAck   = 1'b0;
    MemRData = 32'h0;
    forever begin
      @(posedge Clk);
      #1;
      MemAck = 1'b0;
      if (MemReq && Rst) begin
        if (wait_cnt < (((MemAddr == PCOut) && !MemWe) ? fetch_delay : data_delay)) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          MemAck   = 1'b1;
          MemRData = mem[MemAddr[11:2]];
          if (MemWe) mem[MemAddr[11:2]] = MemWData;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] f);
    return {6'h00, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  // Entered at the negedge of an instruction's first fetch cycle; leaves at the next one's.
  task automatic step(input string tag, input int exp_cyc, input logic [31:0] exp_next);
    int cyc = 1;
    while (!InstrRetired && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
    chk({tag, "_cycles"}, cyc, exp_cyc);
    @(negedge Clk);
    chk({tag, "_next_fetch"}, MemReq ? MemAddr : NOREQ, exp_next);
  endtask

  initial begin
    int req_seen, ret_seen, d;
    logic [5:0]  kfunct [14];
    logic [4:0]  krs [14], krt [14], krd [14];
    logic [15:0] kimm [14];
    bit          kaddi [14];
    logic [31:0] mr [8];
    logic [5:0]  funcs [5];

    funcs = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    Rst = 1'b0;
    Rst0 = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    // Program A: arithmetic and a store
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd7);
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, F_ADD);
    mem[3] = enc_i(OP_SW, 5'd0, 5'd3, 16'd16);
    repeat (3) @(negedge Clk);
    chk("reset_memreq", 32'(MemReq), 32'd0);
    chk("reset_memwe", 32'(MemWe), 32'd0);
    chk("reset_retired", 32'(InstrRetired), 32'd0);
    chk("reset_halted", 32'(Halted), 32'd0);
    chk("reset_pc", PCOut, 32'h0);
    Rst = 1'b1;
    @(negedge Clk);
    chk("first_fetch", MemReq ? MemAddr : NOREQ, 32'h0);
    step("addi_r1", 4, 32'h4);
    step("addi_r2", 4, 32'h8);
    step("add_r3", 4, 32'hC);
    step("sw_r3", 4, 32'h10);
    chk("sw_mem_0x10", mem[4], 32'd12);
    // Word 0x10 now holds 12, which decodes as an illegal funct.
    repeat (2) @(negedge Clk);
    chk("illegal_funct_halt", 32'(Halted), 32'd1);

    // Program B: stalled load, branches, jumps
    Rst = 1'b0;
    mem[0]  = enc_i(OP_LW, 5'd0, 5'd4, 16'd16);
    mem[1]  = enc_i(OP_SW, 5'd0, 5'd4, 16'h200);
    mem[2]  = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd3);
    mem[3]  = enc_j(OP_J, 26'd8);
    mem[8]  = enc_i(OP_BEQ, 5'd1, 5'd1, 16'hFFFF);
    mem[9]  = enc_j(OP_J, 26'd12);
    mem[12] = enc_j(OP_JAL, 26'h40);
    mem[13] = HALT_INSTR;
    mem[64] = enc_i(OP_SW, 5'd0, 5'd31, 16'h204);
    mem[65] = enc_r(5'd31, 5'd0, 5'd0, F_JR);
    mem[128] = 32'h1111_1111;
    mem[129] = 32'h2222_2222;
    data_delay = 3;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    repeat (2) @(negedge Clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk($sformatf("lw_req_hold%0d", k), (MemReq && !MemWe) ? MemAddr : NOREQ, 32'h10);
    end
    @(negedge Clk);
    chk("lw_retire_cycle8", 32'(InstrRetired), 32'd1);
    data_delay = 0;
    @(negedge Clk);
    chk("lw_next_fetch", MemReq ? MemAddr : NOREQ, 32'h4);
    step("sw_r4", 4, 32'h8);
    chk("lw_r4_value", mem[128], 32'd12);
    step("addi_r1b", 4, 32'hC);
    step("j_0x20", 3, 32'h20);
    // The taken branch's refetch of 0x20 sees a not-taken beq instead.
    mem[8] = enc_i(OP_BEQ, 5'd1, 5'd2, 16'd2);
    step("beq_taken", 3, 32'h20);
    step("beq_not_taken", 3, 32'h24);
    step("j_0x30", 3, 32'h30);
    step("jal", 3, 32'h100);
    step("sw_r31", 4, 32'h104);
    chk("jal_r31", mem[129], 32'h34);
    step("jr_r31", 3, 32'h34);
    req_seen = 0;
    ret_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      if (i == 1) chk("halt_not_yet_in_decode", 32'(Halted), 32'd0);
      if (i == 2) chk("halt_after_decode", 32'(Halted), 32'd1);
      if (MemReq) req_seen++;
      if (InstrRetired) ret_seen++;
    end
    chk("halt_no_memreq", req_seen, 0);
    chk("halt_no_retire", ret_seen, 0);
    chk("halt_pc_frozen", PCOut, 32'h38);

    // Program C: reset during a stalled load
    Rst = 1'b0;
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd6, 16'h55);
    mem[1] = enc_i(OP_LW, 5'd0, 5'd7, 16'd16);
    data_delay = 20;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    step("c_addi_r6", 4, 32'h4);
    repeat (3) @(negedge Clk);
    chk("c_in_mem", MemReq ? MemAddr : NOREQ, 32'h10);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_abort_memreq", 32'(MemReq), 32'd0);
    chk("rst_abort_pc", PCOut, 32'h0);
    repeat (2) @(negedge Clk);
    mem[0] = enc_i(OP_SW, 5'd0, 5'd6, 16'h208);
    mem[1] = enc_i(OP_SW, 5'd0, 5'd7, 16'h20C);
    mem[2] = HALT_INSTR;
    mem[130] = 32'h3333_3333;
    mem[131] = 32'h4444_4444;
    data_delay = 0;
    Rst = 1'b1;
    @(negedge Clk);
    step("c_sw_r6", 4, 32'h4);
    step("c_sw_r7", 4, 32'h8);
    chk("rst_clears_r6", mem[130], 32'h0);
    chk("rst_clears_r7", mem[131], 32'h0);

    // Misaligned load on both halt policies
    Rst = 1'b0;
    mem[0] = enc_i(OP_LW, 5'd0, 5'd5, 16'd2);
    mem[1] = HALT_INSTR;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    Rst0 = 1'b1;
    @(negedge Clk);
    req_seen = 0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge Clk);
      if (MemReq) req_seen++;
      if (c == 4) begin
        chk("misalign_halted", 32'(Halted), 32'd1);
        chk("misalign0_addr", MemReq0 ? MemAddr0 : NOREQ, 32'h0);
        chk("misalign0_we", 32'(MemWe0), 32'd0);
        chk("misalign0_wdata", MemWData0, 32'h0);
      end
      if (c == 5) begin
        chk("misalign0_retire", 32'(InstrRetired0), 32'd1);
        chk("misalign0_not_halted", 32'(Halted0), 32'd0);
        chk("misalign0_pc", PCOut0, 32'h4);
      end
    end
    chk("misalign_no_mem_req", req_seen, 0);
    Rst0 = 1'b0;

    // Randomized ALU programs against an ISA-level model
    for (int r = 0; r < 3; r++) begin
      Rst = 1'b0;
      d = $urandom_range(0, 2);
      fetch_delay = d;
      data_delay = d;
      for (int i = 0; i < 8; i++) mr[i] = 32'h0;
      for (int k = 0; k < 14; k++) begin
        kaddi[k]  = ($urandom_range(0, 2) == 0) || (k < 3);
        krs[k]    = 5'($urandom_range(0, 7));
        krt[k]    = 5'($urandom_range(0, 7));
        krd[k]    = 5'($urandom_range(0, 7));
        kimm[k]   = 16'($urandom);
        kfunct[k] = funcs[$urandom_range(0, 4)];
        if (kaddi[k]) begin
          mem[k] = enc_i(OP_ADDI, krs[k], krt[k], kimm[k]);
          if (krt[k] != 0) mr[krt[k]] = mr[krs[k]] + {{16{kimm[k][15]}}, kimm[k]};
        end else begin
          mem[k] = enc_r(krs[k], krt[k], krd[k], kfunct[k]);
          if (krd[k] != 0) begin
            case (kfunct[k])
              F_ADD:   mr[krd[k]] = mr[krs[k]] + mr[krt[k]];
              F_SUB:   mr[krd[k]] = mr[krs[k]] - mr[krt[k]];
              F_AND:   mr[krd[k]] = mr[krs[k]] & mr[krt[k]];
              F_OR:    mr[krd[k]] = mr[krs[k]] | mr[krt[k]];
              default: mr[krd[k]] = ($signed(mr[krs[k]]) < $signed(mr[krt[k]])) ? 32'd1 : 32'd0;
            endcase
          end
        end
      end
      for (int i = 0; i < 8; i++) begin
        mem[14 + i]  = enc_i(OP_SW, 5'd0, 5'(i), 16'(16'h300 + 4 * i));
        mem[192 + i] = 32'hA5A5_0000 | 32'(i);
      end
      mem[22] = HALT_INSTR;
      repeat (2) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      for (int k = 0; k < 22; k++)
        step($sformatf("rnd%0d_i%0d", r, k), (k < 14) ? 4 + d : 4 + 2 * d, 32'(4 * (k + 1)));
      repeat (d + 3) @(negedge Clk);
      chk($sformatf("rnd%0d_halt", r), 32'(Halted), 32'd1);
      for (int i = 0; i < 8; i++)
        chk($sformatf("rnd%0d_r%0d", r, i), mem[192 + i], mr[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
